// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mac_sequencer
// Description : Dot-product sequencer feeding one lane pair per cycle through
//               an external shared SIZExSIZE multiplier, accumulating the sum.
//               Optional MAC_SEQ_ZERO_SKIP_EN skips lanes with a zero operand.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_sequencer #(
    parameter int SIZE = 4,
    parameter int SETS = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       valid,
    input  logic [SIZE*SETS-1:0]       a,
    input  logic [SIZE*SETS-1:0]       b,
    output logic [SIZE-1:0]            mul_a,
    output logic [SIZE-1:0]            mul_b,
    output logic                       mul_valid,
    input  logic [2*SIZE-1:0]          mul_out,
    output logic                       busy,
    output logic                       ready,
    output logic [(SIZE<<1)+SETS-1:0]  out
);

    localparam int ACC_W = (SIZE << 1) + SETS;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SIZE*SETS-1:0] a_q, a_d, b_q, b_d;
    logic [SETS-1:0]    mask_q, mask_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   out_q, out_d;
    logic               ready_q, ready_d;

    logic [SETS-1:0]    w_init_mask;
    logic [SETS-1:0]    w_lane_sel;
    logic [SETS-1:0]    w_mask_rem;
    logic [ACC_W-1:0]   w_acc_sum;

`ifdef MAC_SEQ_ZERO_SKIP_EN
    // A lane needs a multiplier cycle only when both operands are nonzero.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_mask
        assign w_init_mask[gi] = (|a[gi*SIZE +: SIZE]) && (|b[gi*SIZE +: SIZE]);
    end
`else
    assign w_init_mask = '1;
`endif

    // Isolate the lowest pending lane: lanes are served in ascending order.
    assign w_lane_sel = mask_q & (~mask_q + {{(SETS-1){1'b0}}, 1'b1});
    assign w_mask_rem = mask_q & ~w_lane_sel;
    assign w_acc_sum  = acc_q + {{SETS{1'b0}}, mul_out};

    always_comb begin
        mul_a     = '0;
        mul_b     = '0;
        mul_valid = (state_q == S_RUN) && (|mask_q);
        if (state_q == S_RUN) begin
            for (int i = 0; i < SETS; i++) begin
                if (w_lane_sel[i]) begin
                    mul_a = mul_a | a_q[i*SIZE +: SIZE];
                    mul_b = mul_b | b_q[i*SIZE +: SIZE];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mask_d  = mask_q;
        acc_d   = acc_q;
        out_d   = out_q;
        ready_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid) begin
                    a_d     = a;
                    b_d     = b;
                    mask_d  = w_init_mask;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (|mask_q) begin
                    acc_d  = w_acc_sum;
                    mask_d = w_mask_rem;
                    if (w_mask_rem == '0) begin
                        out_d   = w_acc_sum;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    // Nothing to multiply: finish immediately with a zero result.
                    out_d   = acc_q;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mask_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mask_q  <= mask_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            ready_q <= ready_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign ready = ready_q;
    assign out   = out_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_sequencer
// Description : Scoreboard bench for mac_sequencer with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_sequencer;

    localparam int SIZE = 4;
    localparam int SETS = 8;
    localparam int W    = SIZE * SETS;
    localparam int OW   = (SIZE << 1) + SETS;

`ifdef MAC_SEQ_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic            clk     = 1'b0;
    logic            reset_n = 1'b0;
    logic            valid   = 1'b0;
    logic [W-1:0]    a       = '0;
    logic [W-1:0]    b       = '0;
    logic [SIZE-1:0] mul_a;
    logic [SIZE-1:0] mul_b;
    logic            mul_valid;
    logic [2*SIZE-1:0] mul_out;
    logic            busy;
    logic            ready;
    logic [OW-1:0]   out;

    mac_sequencer #(.SIZE(SIZE), .SETS(SETS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid     (valid),
        .a         (a),
        .b         (b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_valid (mul_valid),
        .mul_out   (mul_out),
        .busy      (busy),
        .ready     (ready),
        .out       (out)
    );

    // External combinational multiplier.
    assign mul_out = (2*SIZE)'(mul_a) * (2*SIZE)'(mul_b);

    always #5 clk = ~clk;

    typedef struct {
        int          e0;
        int          k;
        int unsigned sum;
    } op_t;

    typedef struct {
        logic [SIZE-1:0] la;
        logic [SIZE-1:0] lb;
    } lane_t;

    op_t         exp_q[$];
    lane_t       lane_q[$];
    int          cyc       = 0;
    int          checks    = 0;
    int          failures  = 0;
    int          free_edge = 0;
    logic [OW-1:0] last_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: plain dot product; each lane needing a cycle is queued in order.
    function automatic int push_expect(input logic [W-1:0] va, input logic [W-1:0] vb);
        op_t   op;
        lane_t l;
        int    n;
        n      = 0;
        op.sum = 0;
        for (int i = 0; i < SETS; i++) begin
            l.la = va[i*SIZE +: SIZE];
            l.lb = vb[i*SIZE +: SIZE];
            op.sum += int'(l.la) * int'(l.lb);
            if (!SKIP || (l.la != 0 && l.lb != 0)) begin
                lane_q.push_back(l);
                n++;
            end
        end
        op.k  = (n == 0) ? 1 : n;
        op.e0 = cyc + 1;
        exp_q.push_back(op);
        return op.k;
    endfunction

    task automatic wait_free();
        while (cyc + 1 < free_edge) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input bit noise);
        int k;
        wait_free();
        k     = push_expect(va, vb);
        valid = 1'b1;
        a     = va;
        b     = vb;
        free_edge = cyc + 1 + k + 1;
        @(posedge clk); #1;
        while (cyc + 1 < free_edge) begin
            valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            @(posedge clk); #1;
        end
        valid = 1'b0;
    endtask

    task automatic reset_mid_run();
        int k;
        wait_free();
        k     = push_expect(32'h88888888, 32'h88888888);
        valid = 1'b1;
        a     = 32'h88888888;
        b     = 32'h88888888;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        exp_q.delete();
        lane_q.delete();
        last_out = '0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset_n   = 1'b1;
        free_edge = cyc + 1;
    endtask

    op_t   mon_op;
    lane_t mon_l;
    bit    mon_busy;

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_busy", busy, 0);
            check("rst_ready", ready, 0);
            check("rst_mul_valid", mul_valid, 0);
            check("rst_mul_ops", {mul_a, mul_b}, 0);
            check("rst_out", out, 0);
        end else begin
            if (mul_valid) begin
                if (lane_q.size() == 0) begin
                    check("unexpected_mul_valid", 1, 0);
                end else begin
                    mon_l = lane_q.pop_front();
                    check("mul_a", mul_a, mon_l.la);
                    check("mul_b", mul_b, mon_l.lb);
                end
            end else begin
                check("idle_mul_ops_zero", {mul_a, mul_b}, 0);
            end
            mon_busy = (exp_q.size() > 0) && (cyc >= exp_q[0].e0) &&
                       (cyc < exp_q[0].e0 + exp_q[0].k);
            check("busy", busy, mon_busy);
            if (ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    mon_op = exp_q.pop_front();
                    check("ready_cycle", cyc, mon_op.e0 + mon_op.k);
                    check("out", out, mon_op.sum);
                    last_out = OW'(mon_op.sum);
                end
            end else begin
                if (exp_q.size() > 0 && cyc >= exp_q[0].e0 + exp_q[0].k) begin
                    check("missing_ready", 0, 1);
                    void'(exp_q.pop_front());
                end
                check("out_hold", out, last_out);
            end
        end
    end

    initial begin
        logic [W-1:0] va, vb;
        repeat (3) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        free_edge = cyc + 1;

        issue(32'h88888888, 32'h88888888, 1'b0);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        issue(32'h00000003, 32'h00000005, 1'b0);
        issue(32'h00000000, 32'h12345678, 1'b0);
        // Back-to-back: second request is accepted in the first one's ready cycle.
        issue(32'h11111111, 32'h22222222, 1'b1);
        issue(32'h88888888, 32'h88888888, 1'b0);
        reset_mid_run();
        issue(32'h00000003, 32'h00000005, 1'b0);

        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            for (int i = 0; i < SETS; i++) begin
                va[i*SIZE +: SIZE] = ($urandom_range(0, 3) == 0) ? '0 : SIZE'($urandom);
                vb[i*SIZE +: SIZE] = ($urandom_range(0, 3) == 0) ? '0 : SIZE'($urandom);
            end
            issue(va, vb, 1'($urandom_range(0, 1)));
        end

        repeat (SETS + 4) @(posedge clk);
        #1;
        check("queues_drained", exp_q.size() + lane_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mac_sequencer.md
# mac_sequencer

Time-multiplexed dot-product controller: accepts two packed vectors of `SETS` unsigned `SIZE`-bit lanes and sequences them, one lane pair per cycle, through a single shared combinational `SIZE`x`SIZE` multiplier, accumulating the products. It sits in the conventional MAC path as the sequential alternative to a fully parallel binary MAC, trading latency for one multiplier instance. The multiplier is external; this block drives its operands and consumes its product in the same cycle.

## Interface

- `SIZE`, 4, lane width in bits (unsigned)
- `SETS`, 8, lanes per vector
- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `valid`  in  1  request strobe; sampled only in IDLE
- `a`  in  `SIZE*SETS`  operand vector; lane i = bits `[i*SIZE +: SIZE]`
- `b`  in  `SIZE*SETS`  operand vector, same packing
- `mul_a`  out  `SIZE`  multiplier operand A
- `mul_b`  out  `SIZE`  multiplier operand B
- `mul_valid`  out  1  high when a lane is being processed this cycle
- `mul_out`  in  `2*SIZE`  combinational product of `mul_a*mul_b`
- `busy`  out  1  high while in RUN
- `ready`  out  1  one-cycle completion pulse
- `out`  out  `(SIZE<<1)+SETS`  dot-product result, held until next completion

## Operation

- States: IDLE, RUN. Reset: IDLE, `out`=0, `ready`=0, `busy`=0, `mul_valid`=0, `mul_a`=`mul_b`=0, accumulator and lane mask cleared.
- IDLE, `valid`=1 at edge: register `a`, `b`; load lane mask `m`; clear accumulator; go to RUN. `valid`=0: stay.
- Lane mask: bit i set means lane i needs a cycle (see Configuration).
- RUN, each cycle: select lowest set bit j of `m`. If `m`!=0: `mul_a`=a_reg lane j, `mul_b`=b_reg lane j, `mul_valid`=1; at edge, acc += `mul_out` (zero-extended), clear bit j.
- RUN completion: at the edge where `m` becomes (or already is) zero: `out` <= final sum, `ready` <= 1, state <= IDLE. If `m`=0 on entry (nothing to do): `mul_valid`=0 that cycle, `out` <= 0, complete at that edge.
- `mul_a`/`mul_b` are 0 whenever `mul_valid`=0.
- `valid` while busy: ignored, not queued; `a`/`b` changes during RUN have no effect.
- Arithmetic unsigned; accumulator width `(SIZE<<1)+SETS`; no overflow possible (max `SETS*(2^SIZE-1)^2`).

## Timing

- Accept edge E0 (IDLE, `valid`=1). RUN lasts k = max(1, popcount(m)) cycles; `ready` high for exactly the cycle after edge Ek, `out` valid from that same cycle.
- Without macro: k = `SETS` (8 at default).
- `ready` and IDLE coincide: `valid` high during the `ready` cycle is accepted at that edge; `valid` held high gives back-to-back operations with one IDLE cycle each (throughput one result per k+1 cycles).
- `busy` high from cycle after E0 through cycle ending at Ek.
- `reset_n` low mid-RUN: immediate return to reset values; no `ready` pulse for the aborted operation; `out` cleared to 0.

## Configuration

- `MAC_SEQ_ZERO_SKIP_EN` defined: at accept, mask bit i = (a lane i != 0) && (b lane i != 0); zero-product lanes consume no cycle; latency data-dependent, k = max(1, count of nonzero pairs).
- Undefined: mask = all ones; every lane takes one cycle, including zeros; latency fixed at `SETS` cycles. Results identical in both builds.

## Test plan

- `a`=`b`=32'h88888888 -> `out`=512, `ready` after E8 in both builds; `mul_valid` high 8 cycles, lanes in order 0..7.
- `a`=`b`=32'hFFFFFFFF -> `out`=1800 (no overflow), `ready` after E8.
- `a`=32'h00000003, `b`=32'h00000005 -> `out`=15; `ready` after E8 without macro, after E1 with macro (only lane 0 to multiplier).
- `a`=32'h00000000, `b`=32'h12345678 -> `out`=0; `ready` after E8 without macro; with macro `ready` after E1 and `mul_valid` never high.
- `valid` held high, vectors 32'h11111111 x 32'h22222222 then 32'h88888888 x 32'h88888888 -> `out`=16 then 512, second accepted in the first's `ready` cycle; pulses of `valid` during RUN ignored.
- `reset_n` low after E4 of a run -> `busy`=0, `out`=0, no `ready`; fresh request after release completes normally.
